// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and registers the fetched word into the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [31:0] id_instr,
   output logic        id_adel,
   output logic [31:0] fetch_count
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP = '0;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            id_valid_q, id_valid_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
   logic [XLEN-1:0] id_instr_q, id_instr_d;
   logic            id_adel_q, id_adel_d;
   logic [XLEN-1:0] fetch_count_q, fetch_count_d;

   logic [XLEN-1:0] pc_plus4;
   logic            pc_misaligned;

   assign pc_plus4      = pc_q + XLEN'(4);
   assign pc_misaligned = (pc_q[1:0] != 2'b00);

   // Redirect beats stall; a misaligned PC keeps advancing and delivers flagged NOPs.
   always_comb begin
      pc_d          = pc_q;
      id_valid_d    = id_valid_q;
      id_pc_d       = id_pc_q;
      id_pc_plus4_d = id_pc_plus4_q;
      id_instr_d    = id_instr_q;
      id_adel_d     = id_adel_q;
      fetch_count_d = fetch_count_q;
      if (redirect_valid) begin
         pc_d       = redirect_pc;
         id_valid_d = 1'b0;
         id_instr_d = NOP;
         id_adel_d  = 1'b0;
      end else if (!stall) begin
         pc_d          = pc_plus4;
         id_valid_d    = 1'b1;
         id_pc_d       = pc_q;
         id_pc_plus4_d = pc_plus4;
         id_adel_d     = pc_misaligned;
         id_instr_d    = pc_misaligned ? NOP : imem_rdata;
         fetch_count_d = fetch_count_q + XLEN'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         id_valid_q    <= 1'b0;
         id_pc_q       <= '0;
         id_pc_plus4_q <= '0;
         id_instr_q    <= '0;
         id_adel_q     <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         pc_q          <= pc_d;
         id_valid_q    <= id_valid_d;
         id_pc_q       <= id_pc_d;
         id_pc_plus4_q <= id_pc_plus4_d;
         id_instr_q    <= id_instr_d;
         id_adel_q     <= id_adel_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign id_valid    = id_valid_q;
   assign id_pc       = id_pc_q;
   assign id_pc_plus4 = id_pc_plus4_q;
   assign id_instr    = id_instr_q;
   assign id_adel     = id_adel_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model pushes the expected IF/ID
// state per edge into a queue that is popped and compared after the edge.
module tb_fetch_stage;

   typedef struct {
      logic        flush;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        adel;
      logic [31:0] count;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;
   logic        id_adel;
   logic [31:0] fetch_count;

   int n_assert = 0;
   int n_fail   = 0;

   exp_t        sb_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_count;
   logic        m_valid;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_pc4;
   logic [31:0] m_instr;
   logic        m_adel;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
      .id_instr(id_instr), .id_adel(id_adel), .fetch_count(fetch_count)
   );

   always #50 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: imem_word = 32'h2008_0005;
         32'h0000_0004: imem_word = 32'h2009_0003;
         default:       imem_word = a ^ 32'h3C00_A5A5;
      endcase
   endfunction

   assign imem_rdata = imem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_count = '0; m_valid = 1'b0;
      m_id_pc = '0; m_id_pc4 = '0; m_instr = '0; m_adel = 1'b0;
      sb_q.delete();
   endtask

   // Drive one cycle of inputs, predict the post-edge state, then compare after the edge.
   task automatic step(input logic s, input logic r, input logic [31:0] rpc);
      exp_t e;
      exp_t got;
      stall = s; redirect_valid = r; redirect_pc = rpc;
      e.flush = r;
      if (r) begin
         m_pc = rpc; m_valid = 1'b0; m_instr = '0; m_adel = 1'b0;
      end else if (!s) begin
         m_valid  = 1'b1;
         m_id_pc  = m_pc;
         m_id_pc4 = m_pc + 32'd4;
         m_adel   = (m_pc[1:0] != 2'b00);
         m_instr  = m_adel ? 32'h0 : imem_word(m_pc);
         m_count  = m_count + 32'd1;
         m_pc     = m_pc + 32'd4;
      end
      e.addr = m_pc; e.valid = m_valid; e.pc = m_id_pc; e.pc4 = m_id_pc4;
      e.instr = m_instr; e.adel = m_adel; e.count = m_count;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      n_assert++;
      assert (sb_q.size() > 0) else begin
         n_fail++;
         $error("FAIL sb_empty: observed %0d expected >0", sb_q.size());
      end
      if (sb_q.size() > 0) begin
         got = sb_q.pop_front();
         check("imem_addr",   imem_addr,          got.addr);
         check("id_valid",    32'(id_valid),      32'(got.valid));
         check("id_instr",    id_instr,           got.instr);
         check("id_adel",     32'(id_adel),       32'(got.adel));
         check("fetch_count", fetch_count,        got.count);
         if (!got.flush) begin
            check("id_pc",       id_pc,       got.pc);
            check("id_pc_plus4", id_pc_plus4, got.pc4);
         end
      end
      stall = 1'b0; redirect_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_addr"},  imem_addr,          32'h0);
      check({tag, "_valid"}, 32'(id_valid),      32'h0);
      check({tag, "_pc"},    id_pc,              32'h0);
      check({tag, "_pc4"},   id_pc_plus4,        32'h0);
      check({tag, "_instr"}, id_instr,           32'h0);
      check({tag, "_adel"},  32'(id_adel),       32'h0);
      check({tag, "_count"}, fetch_count,        32'h0);
   endtask

   initial begin
      // Reset window 110..210 ns, edges at 50 + 100k ns.
      #110 rst = 1'b1;
      #1 check_reset_values("rst_during");
      model_reset();
      #99 rst = 1'b0;

      // Startup sequence.
      step(1'b0, 1'b0, 32'h0);
      check("start_instr", id_instr,    32'h2008_0005);
      check("start_pc",    id_pc,       32'h0);
      check("start_pc4",   id_pc_plus4, 32'h4);
      check("start_count", fetch_count, 32'd1);
      step(1'b0, 1'b0, 32'h0);
      check("second_instr", id_instr, 32'h2009_0003);
      step(1'b0, 1'b0, 32'h0);
      check("pre_stall_pc", id_pc, 32'h8);

      // Stall for three edges.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0);
         check("stall_pc",    id_pc,       32'h8);
         check("stall_addr",  imem_addr,   32'hC);
         check("stall_count", fetch_count, 32'd3);
      end
      step(1'b0, 1'b0, 32'h0);
      check("post_stall_pc", id_pc, 32'hC);

      // Stall glitch between edges has no effect.
      #20 stall = 1'b1;
      #20 stall = 1'b0;
      step(1'b0, 1'b0, 32'h0);
      check("glitch_pc", id_pc, 32'h10);

      // Redirect to 0x40.
      step(1'b0, 1'b1, 32'h40);
      check("redir_valid", 32'(id_valid), 32'h0);
      check("redir_instr", id_instr,      32'h0);
      check("redir_addr",  imem_addr,     32'h40);
      step(1'b0, 1'b0, 32'h0);
      check("redir_tgt_pc",    id_pc,         32'h40);
      check("redir_tgt_valid", 32'(id_valid), 32'h1);

      // Redirect and stall in the same cycle.
      step(1'b1, 1'b1, 32'h80);
      check("rs_addr",  imem_addr,     32'h80);
      check("rs_valid", 32'(id_valid), 32'h0);
      step(1'b0, 1'b0, 32'h0);

      // Misaligned redirect.
      step(1'b0, 1'b1, 32'h42);
      step(1'b0, 1'b0, 32'h0);
      check("mis_adel",  32'(id_adel), 32'h1);
      check("mis_instr", id_instr,     32'h0);
      check("mis_pc",    id_pc,        32'h42);
      step(1'b0, 1'b0, 32'h0);
      check("mis2_pc",   id_pc,        32'h46);
      check("mis2_adel", 32'(id_adel), 32'h1);

      // Wrap at the top of the address space.
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0);
      check("wrap_pc4",  id_pc_plus4, 32'h0);
      check("wrap_addr", imem_addr,   32'h0);
      step(1'b0, 1'b0, 32'h0);
      check("wrap_next_pc", id_pc, 32'h0);

      // Asynchronous reset mid-cycle with a pending stall/redirect.
      #30;
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
      rst = 1'b1;
      #5 check_reset_values("async_rst");
      model_reset();
      stall = 1'b0; redirect_valid = 1'b0;
      #10 rst = 1'b0;
      step(1'b0, 1'b0, 32'h0);
      check("restart_instr", id_instr,    32'h2008_0005);
      check("restart_count", fetch_count, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish by 100000 ns");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the ExploreMIPS pipeline, instantiated inside `Top` as the first stage after reset. It owns the program counter and drives the instruction-memory address. It registers the fetched word into the IF/ID pipeline register consumed by the decode stage. It honours stall requests from the hazard unit and PC redirects (branch/jump/exception) from later stages, and keeps a count of delivered instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hold PC and the IF/ID register.
- `redirect_valid`  in  1: load `redirect_pc` and flush IF/ID.
- `redirect_pc`  in  32: redirect target.
- `imem_addr`  out  32: instruction-memory address; equals the PC register (combinational).
- `imem_rdata`  in  32: instruction word at `imem_addr`; asynchronous read, valid in the same cycle.
- `id_valid`  out  1: IF/ID holds a real instruction.
- `id_pc`  out  32: PC of the instruction in IF/ID.
- `id_pc_plus4`  out  32: `id_pc + 4`, modulo 2^32.
- `id_instr`  out  32: instruction word; 32'h0 (NOP) when invalid or faulted.
- `id_adel`  out  1: fetch address misaligned (`id_pc[1:0] != 0`).
- `fetch_count`  out  32: number of instructions delivered to IF/ID.

## Operation
- Reset values while `rst`=1, applied asynchronously:
  - PC = `RESET_PC`.
  - `id_valid`=0, `id_pc`=0, `id_pc_plus4`=0, `id_instr`=0, `id_adel`=0.
  - `fetch_count`=0.
- PC update, priority high to low:
  - `redirect_valid`: PC <= `redirect_pc`. Redirect wins over `stall`.
  - `stall`: PC holds.
  - Otherwise: PC <= PC + 4. Wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- IF/ID update, same priority:
  - `redirect_valid`: flush. `id_valid`<=0, `id_instr`<=0, `id_adel`<=0; `id_pc`/`id_pc_plus4` may keep their old values.
  - `stall`: all `id_*` hold.
  - Otherwise:
    - `id_valid`<=1, `id_pc`<=PC, `id_pc_plus4`<=PC+4.
    - `id_adel`<=(PC[1:0]!=0).
    - `id_instr`<=`imem_rdata` if aligned, else 32'h0.
- Misaligned PC (from a redirect):
  - Fetch continues sequentially at PC+4, still misaligned.
  - Every delivered word is flagged `id_adel`=1 with a NOP instruction.
  - Later stages raise the exception and redirect; this block never self-corrects.
- `fetch_count` increments by 1 on every edge where `id_valid` is loaded with 1, i.e. no redirect and no stall. Wraps at 2^32. It is not incremented on flush or stall edges.
- Stall and redirect are sampled only at the clock edge; glitches between edges have no effect.

## Timing
- Fetch latency is one cycle: word at `imem_addr`=A during cycle N appears on `id_instr` with `id_pc`=A after edge N.
- Redirect asserted in cycle N:
  - After edge N: `imem_addr`=`redirect_pc` and `id_valid`=0 (one-cycle bubble).
  - After edge N+1: target instruction is in IF/ID (if no stall).
- Stall held for k cycles freezes all outputs, including `imem_addr`, for k edges.
- First edge after `rst` falls delivers the `RESET_PC` instruction. `id_valid`=1 from that edge.
- `rst` asserted mid-operation clears all state immediately, without waiting for a clock edge. Any in-flight redirect or stall is discarded.

## Test plan
- **Reset/startup.** Clock period 100 ns; `rst` high from 110 ns to 210 ns; imem[0]=32'h2008_0005, imem[4]=32'h2009_0003.
  - During reset: `imem_addr`=0, `id_valid`=0.
  - First edge after release: `id_instr`=32'h2008_0005, `id_pc`=0, `id_pc_plus4`=4, `fetch_count`=1.
  - Next edge: `id_instr`=32'h2009_0003.
- **Stall.** Assert `stall` for 3 cycles while `id_pc`=8.
  - `id_pc` stays 8 and `imem_addr` stays 12 for 3 edges; `fetch_count` is unchanged.
  - After release: `id_pc`=12.
- **Redirect.** Pulse `redirect_valid` with `redirect_pc`=32'h40.
  - Next edge: `id_valid`=0, `id_instr`=0, `imem_addr`=32'h40.
  - Following edge: `id_pc`=32'h40, `id_valid`=1.
- **Redirect and stall together.** Both asserted in the same cycle: redirect wins, so `imem_addr`=`redirect_pc` and `id_valid`=0 after the edge.
- **Misaligned redirect.** `redirect_pc`=32'h42.
  - Next delivered entry: `id_adel`=1, `id_instr`=0, `id_pc`=32'h42.
  - Following entry: `id_pc`=32'h46, `id_adel`=1.
- **Wrap and async reset.**
  - Redirect to 32'hFFFF_FFFC: after two edges `id_pc_plus4`=0 and `imem_addr`=0.
  - Assert `rst` mid-cycle, away from any clock edge: all outputs reach reset values before the next edge.
